// File: rtl/accel_job_sched_if.sv
// Job scheduler bus bundle: two requester ports, the response port and the accelerator register bus.
// The master modport is the environment (requesters, response sink, accelerator); the slave modport is the scheduler.
interface accel_job_sched_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_key;
  logic [127:0] req0_pt;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_key;
  logic [127:0] req1_pt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_ct;
  logic         rsp_timeout;
  logic [31:0]  acc_addr;
  logic         acc_wr_en;
  logic         acc_select;
  logic [31:0]  acc_wdata;
  logic [31:0]  acc_rdata;

  modport master (
    output req0_valid, req0_key, req0_pt, req1_valid, req1_key, req1_pt, rsp_ready, acc_rdata,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ct, rsp_timeout,
    input  acc_addr, acc_wr_en, acc_select, acc_wdata
  );

  modport slave (
    input  req0_valid, req0_key, req0_pt, req1_valid, req1_key, req1_pt, rsp_ready, acc_rdata,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ct, rsp_timeout,
    output acc_addr, acc_wr_en, acc_select, acc_wdata
  );
endinterface

// File: rtl/accel_job_sched.sv
// Round-robin scheduler feeding jobs from two requesters through a register-mapped cipher accelerator.
// Optional key cache (skips key writes when the key repeats): define ACCEL_JOB_SCHED_KEY_CACHE_EN.
module accel_job_sched #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  accel_job_sched_if.slave bus,
  output logic             busy
);
  localparam int PCNT_W = ($clog2(TIMEOUT_CYCLES + 2) > 8) ? $clog2(TIMEOUT_CYCLES + 2) : 8;
  localparam logic [31:0] CTRL_ADDR = 32'h20;
  localparam logic [31:0] KEY_BASE  = 32'h28;
  localparam logic [31:0] PT_BASE   = 32'h38;
  localparam logic [31:0] CT_BASE   = 32'h48;

  typedef enum logic [2:0] {IDLE, WR_KEY, WR_PT, GO, POLL, RD_CT, RESP} state_t;

  state_t              state;
  logic [1:0]          idx;
  logic [1:0]          nxt;
  logic [PCNT_W-1:0]   poll_cnt;
  logic                prio;
  logic [127:0]        key_q;
  logic [127:0]        pt_q;
  logic                grant0;
  logic                grant1;
  logic [127:0]        sel_key;
  logic [127:0]        sel_pt;
  logic                key_hit;
  logic                poll_abort;

  function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // prio names the requester that wins a tie
  assign grant0     = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio);
  assign grant1     = (state == IDLE) && bus.req1_valid && (!bus.req0_valid || prio);
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign nxt        = idx + 2'd1;
  assign sel_key    = grant1 ? bus.req1_key : bus.req0_key;
  assign sel_pt     = grant1 ? bus.req1_pt  : bus.req0_pt;
  assign poll_abort = (state == POLL) && !bus.acc_rdata[31] &&
                      (poll_cnt >= PCNT_W'(TIMEOUT_CYCLES));

`ifdef ACCEL_JOB_SCHED_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic         cache_vld;

  assign key_hit = cache_vld && (cache_key == sel_key);

  // The cache tracks what the accelerator holds, so it is refreshed once the last key word lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key <= '0;
      cache_vld <= 1'b0;
    end else if (poll_abort) begin
      cache_vld <= 1'b0;
    end else if (state == WR_KEY && idx == 2'd3) begin
      cache_key <= key_q;
      cache_vld <= 1'b1;
    end
  end
`else
  assign key_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      poll_cnt        <= '0;
      prio            <= 1'b0;
      key_q           <= '0;
      pt_q            <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= 1'b0;
      bus.rsp_ct      <= '0;
      bus.rsp_timeout <= 1'b0;
      bus.acc_addr    <= '0;
      bus.acc_wr_en   <= 1'b0;
      bus.acc_select  <= 1'b0;
      bus.acc_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            key_q           <= sel_key;
            pt_q            <= sel_pt;
            bus.rsp_id      <= grant1;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_ct      <= '0;
            prio            <= grant0;
            idx             <= '0;
            bus.acc_wr_en   <= 1'b1;
            bus.acc_select  <= 1'b1;
            if (key_hit) begin
              state         <= WR_PT;
              bus.acc_addr  <= PT_BASE;
              bus.acc_wdata <= sel_pt[31:0];
            end else begin
              state         <= WR_KEY;
              bus.acc_addr  <= KEY_BASE;
              bus.acc_wdata <= sel_key[31:0];
            end
          end
        end
        WR_KEY: begin
          idx <= nxt;
          if (idx == 2'd3) begin
            state         <= WR_PT;
            bus.acc_addr  <= PT_BASE;
            bus.acc_wdata <= pt_q[31:0];
          end else begin
            bus.acc_addr  <= KEY_BASE + {28'd0, nxt, 2'b00};
            bus.acc_wdata <= key_q[{nxt, 5'b0} +: 32];
          end
        end
        WR_PT: begin
          idx <= nxt;
          if (idx == 2'd3) begin
            state         <= GO;
            poll_cnt      <= '0;
            bus.acc_addr  <= CTRL_ADDR;
            bus.acc_wdata <= 32'h0000_0001;
          end else begin
            bus.acc_addr  <= PT_BASE + {28'd0, nxt, 2'b00};
            bus.acc_wdata <= pt_q[{nxt, 5'b0} +: 32];
          end
        end
        GO: begin
          state         <= POLL;
          bus.acc_wr_en <= 1'b0;
          bus.acc_wdata <= '0;
        end
        POLL: begin
          // done wins over the timeout when both land on the same poll
          if (bus.acc_rdata[31]) begin
            state        <= RD_CT;
            idx          <= '0;
            bus.acc_addr <= CT_BASE;
          end else if (poll_abort) begin
            state           <= RESP;
            bus.acc_addr    <= '0;
            bus.acc_select  <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_ct      <= '0;
          end else begin
            poll_cnt <= sat_inc(poll_cnt);
          end
        end
        RD_CT: begin
          bus.rsp_ct[{idx, 5'b0} +: 32] <= bus.acc_rdata;
          idx <= nxt;
          if (idx == 2'd3) begin
            state          <= RESP;
            bus.acc_addr   <= '0;
            bus.acc_select <= 1'b0;
            bus.rsp_valid  <= 1'b1;
          end else begin
            bus.acc_addr <= CT_BASE + {28'd0, nxt, 2'b00};
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_job_sched.sv
// Randomized bench for accel_job_sched: behavioural accelerator plus a job-level reference model.
module tb_accel_job_sched;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  accel_job_sched_if bus();

  accel_job_sched #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- accelerator model ----------------
  logic [31:0] akey [4];
  logic [31:0] apt  [4];
  int  acnt = 0;
  bit  astarted = 0;
  bit  hang = 0;
  int  lat = 0;

  function automatic logic [31:0] mul32(input logic [31:0] k, input logic [31:0] p);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = k[8*b +: 8] * p[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] widx(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] off;
    off = a - base;
    return off[3:2];
  endfunction

  always @(posedge clk) begin
    if (bus.acc_wr_en && bus.acc_select) begin
      if (bus.acc_addr >= 32'h28 && bus.acc_addr <= 32'h34) akey[widx(bus.acc_addr, 32'h28)] <= bus.acc_wdata;
      else if (bus.acc_addr >= 32'h38 && bus.acc_addr <= 32'h44) apt[widx(bus.acc_addr, 32'h38)] <= bus.acc_wdata;
      else if (bus.acc_addr == 32'h20 && bus.acc_wdata[0]) begin
        astarted <= 1'b1;
        acnt     <= lat;
      end
    end else if (acnt > 0) begin
      acnt <= acnt - 1;
    end
  end

  always_comb begin
    bus.acc_rdata = '0;
    if (bus.acc_select && !bus.acc_wr_en) begin
      if (bus.acc_addr == 32'h20)
        bus.acc_rdata[31] = astarted && (acnt == 0) && !hang;
      else if (bus.acc_addr >= 32'h48 && bus.acc_addr <= 32'h54)
        bus.acc_rdata = mul32(akey[widx(bus.acc_addr, 32'h48)], apt[widx(bus.acc_addr, 32'h48)]);
    end
  end

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
    bit          s;
  } wr_t;
  wr_t wlog[$];

  always @(negedge clk) if (bus.acc_wr_en) wlog.push_back('{cyc, bus.acc_addr, bus.acc_wdata, bus.acc_select});

  // ---------------- reference model state ----------------
  bit           prio_m = 0;
  bit           cache_vld_m = 0;
  logic [127:0] cache_key_m = '0;
  logic [127:0] last_ct;

  function automatic logic [127:0] ct_ref(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = k[8*i +: 8] * p[8*i +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    prio_m      = 1'b0;
    cache_vld_m = 1'b0;
    @(negedge clk);
  endtask

  // Runs one job from the currently asserted request(s); called at a negedge.
  task automatic do_job(input int delay);
    bit got, g, exp_id, hit, to_exp, seen;
    int t, nwr, lat_exp, errs, jj;
    logic [127:0] key, pt, ct_exp, hct;
    logic hid, hto;
    logic [31:0] ea, ed;

    exp_id = (bus.req0_valid && bus.req1_valid) ? prio_m : !bus.req0_valid;
    key    = exp_id ? bus.req1_key : bus.req0_key;
    pt     = exp_id ? bus.req1_pt  : bus.req0_pt;
    got    = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req0_ready || bus.req1_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check_val("handshake_seen", got, 1);
    if (!got) return;
    g = bus.req1_ready;
    check_val("grant_id", g, exp_id);
    check_val("single_grant", bus.req0_ready & bus.req1_ready, 0);

    prio_m = !exp_id;
`ifdef ACCEL_JOB_SCHED_KEY_CACHE_EN
    hit = cache_vld_m && (cache_key_m == key);
`else
    hit = 0;
`endif
    nwr     = hit ? 5 : 9;
    to_exp  = hang || (lat + 1 > TIMEOUT);
    lat_exp = nwr + (to_exp ? TIMEOUT + 2 : lat + 1 + 5);
    ct_exp  = to_exp ? '0 : ct_ref(key, pt);
    if (!hit) begin
      cache_key_m = key;
      cache_vld_m = 1;
    end
    if (to_exp) cache_vld_m = 0;

    t = cyc;
    wlog.delete();
    @(posedge clk);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (g) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
      end
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check_val("rsp_seen", seen, 1);
    if (!seen) return;
    check_val("latency", cyc - t, lat_exp);
    check_val("rsp_id", bus.rsp_id, exp_id);
    check_val("rsp_ct", bus.rsp_ct, ct_exp);
    check_val("rsp_timeout", bus.rsp_timeout, to_exp);
    last_ct = bus.rsp_ct;

    check_val("wr_count", wlog.size(), nwr);
    errs = 0;
    for (int j = 0; j < nwr && j < wlog.size(); j++) begin
      jj = hit ? j + 4 : j;
      if (jj < 4) begin
        ea = 32'h28 + 32'(4 * jj);
        ed = key[32*jj +: 32];
      end else if (jj < 8) begin
        ea = 32'h38 + 32'(4 * (jj - 4));
        ed = pt[32*(jj-4) +: 32];
      end else begin
        ea = 32'h20;
        ed = 32'h1;
      end
      if (wlog[j].a !== ea || wlog[j].d !== ed || wlog[j].c != t + 1 + j || !wlog[j].s) errs++;
    end
    check_val("wr_seq", errs, 0);

    hid  = bus.rsp_id;
    hct  = bus.rsp_ct;
    hto  = bus.rsp_timeout;
    errs = 0;
    repeat (delay) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_id !== hid || bus.rsp_ct !== hct || bus.rsp_timeout !== hto ||
          bus.req0_ready || bus.req1_ready || !busy) errs++;
    end
    if (delay > 0) check_val("rsp_hold", errs, 0);

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_val("rsp_release", {bus.rsp_valid, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit got, found;
    int errs, pat;
    logic [127:0] k_last;

    bus.req0_valid = 0; bus.req0_key = '0; bus.req0_pt = '0;
    bus.req1_valid = 0; bus.req1_key = '0; bus.req1_pt = '0;
    bus.rsp_ready  = 0;
    repeat (2) @(negedge clk);
    check_val("reset_ctrl", {busy, bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                             bus.rsp_timeout, bus.acc_wr_en, bus.acc_select}, 0);
    check_val("reset_ct", bus.rsp_ct, 0);
    check_val("reset_acc", {bus.acc_addr, bus.acc_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single reference job with known bytes
    bus.req0_key   = {96'h0, 32'h0403_0201};
    bus.req0_pt    = {96'h0, 32'h0807_0605};
    bus.req0_valid = 1'b1;
    lat = 5;
    do_job(0);
    check_val("ct_word0", last_ct[31:0], 32'h2015_0C05);

    // simultaneous requests after reset, then again
    do_reset();
    bus.req0_key = rnd128(); bus.req0_pt = rnd128();
    bus.req1_key = rnd128(); bus.req1_pt = rnd128();
    bus.req0_valid = 1; bus.req1_valid = 1;
    lat = 2;
    do_job(0);
    do_job(0);
    bus.req0_valid = 1; bus.req1_valid = 1;
    do_job(0);
    do_job(0);

    // response back-pressure with the other requester waiting
    bus.req0_valid = 1; bus.req1_valid = 1;
    do_job(10);
    do_job(0);

    // same key twice from requester 1
    bus.req1_key = rnd128(); bus.req1_pt = rnd128(); bus.req1_valid = 1;
    do_job(0);
    bus.req1_pt = rnd128(); bus.req1_valid = 1;
    do_job(0);

    // poll timeout, then the same key again
    hang = 1;
    bus.req0_key = rnd128(); bus.req0_pt = rnd128(); bus.req0_valid = 1;
    do_job(2);
    hang = 0;
    bus.req0_valid = 1;
    do_job(0);

    // reset in the middle of the plaintext writes
    bus.req0_key = rnd128(); bus.req0_pt = rnd128(); bus.req0_valid = 1;
    lat = 3;
    got = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req0_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check_val("rst_job_accept", got, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.acc_wr_en && bus.acc_addr == 32'h38) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_val("reach_wr_pt", found, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_ctrl", {busy, bus.acc_wr_en, bus.acc_select, bus.rsp_valid,
                               bus.req0_ready, bus.req1_ready}, 0);
    check_val("rst_mid_bus", {bus.acc_addr, bus.acc_wdata}, 0);
    prio_m = 0;
    cache_vld_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) errs++;
    end
    check_val("no_rsp_after_rst", errs, 0);
    bus.req0_valid = 1;
    do_job(0);

    // randomized traffic
    k_last = bus.req0_key;
    for (int n = 0; n < 16; n++) begin
      if (!bus.req0_valid && !bus.req1_valid) begin
        pat = $urandom_range(1, 3);
        if (pat[0]) begin
          bus.req0_key = ($urandom_range(0, 1) == 0) ? k_last : rnd128();
          bus.req0_pt  = rnd128();
          bus.req0_valid = 1;
          k_last = bus.req0_key;
        end
        if (pat[1]) begin
          bus.req1_key = ($urandom_range(0, 1) == 0) ? k_last : rnd128();
          bus.req1_pt  = rnd128();
          bus.req1_valid = 1;
          k_last = bus.req1_key;
        end
      end
      hang = ($urandom_range(0, 5) == 0);
      lat  = $urandom_range(0, 20);
      do_job($urandom_range(0, 3));
    end
    hang = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/accel_job_sched.md
ACCEL_JOB_SCHED -- requirements
Module: accel_job_sched

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max status-poll cycles per job before abort.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req0_ready  in/out  1/1  requester 0 (CPU) job handshake.
REQ-005 req0_key / req0_pt  input  128/128  requester 0 key and plaintext; word k = bits [32k+31:32k].
REQ-006 req1_valid, req1_ready, req1_key, req1_pt  same as REQ-004/005 for requester 1 (DMA).
REQ-007 rsp_valid / rsp_ready  out/in  1/1  result handshake.
REQ-008 rsp_id  output  1  requester index of returned job.
REQ-009 rsp_ct  output  128  ciphertext; word k read from accelerator ciphertext word k.
REQ-010 rsp_timeout  output  1  job aborted by poll timeout.
REQ-011 acc_addr  output  32  accelerator byte address (word index in bits [6:2]).
REQ-012 acc_wr_en, acc_select  output  1/1  accelerator write strobe and select.
REQ-013 acc_wdata / acc_rdata  out/in  32/32  write data; combinational read data for acc_addr.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Accelerator map (byte addr): 0x20 ctrl/status (bit0 go, bit31 done), 0x28-0x34 key[0..3], 0x38-0x44 pt[0..3], 0x48-0x54 ct[0..3].
REQ-016 FSM states: IDLE, WR_KEY, WR_PT, GO, POLL, RD_CT, RESP.
REQ-017 IDLE: reqN_ready high only for the arbitration winner; handshake latches key, pt, id; next state WR_KEY.
REQ-018 Arbitration round-robin: one valid wins; both valid -> requester not granted last wins; after reset requester 0 has priority.
REQ-019 WR_KEY: 4 consecutive cycles, acc_wr_en=acc_select=1, addr 0x28,0x2C,0x30,0x34, data key word 0..3.
REQ-020 WR_PT: 4 cycles, same rule, addr 0x38..0x44, data pt word 0..3.
REQ-021 GO: 1 cycle, write 0x00000001 to 0x20.
REQ-022 POLL: acc_addr=0x20, acc_select=1, acc_wr_en=0; acc_rdata[31]=1 -> RD_CT.
REQ-023 POLL cycle count > TIMEOUT_CYCLES -> RESP with rsp_timeout=1, rsp_ct=0.
REQ-024 RD_CT: 4 cycles, addr 0x48..0x54, capture acc_rdata into ct word 0..3, then RESP.
REQ-025 RESP: rsp_valid held with stable rsp_id/rsp_ct/rsp_timeout until rsp_ready; then IDLE.
REQ-026 No new request accepted while busy; reqN_ready=0 outside IDLE.
REQ-027 acc_wr_en, acc_select, acc_wdata zero outside write/poll/read cycles.
REQ-028 Requests while rsp_valid pending wait; no response dropped or overwritten.
REQ-029 Poll counter 8 bits min, saturating; cleared on GO entry.

Reset
REQ-030 rst_n low -> IDLE immediately, including mid-job; job discarded, no response.
REQ-031 Reset values: all outputs 0, rr-pointer to requester 0, latched job data and key cache cleared.

Configuration
REQ-032 Macro ACCEL_JOB_SCHED_KEY_CACHE_EN defined: stores last key written; job with identical key and cache valid skips WR_KEY (IDLE -> WR_PT); cache invalidated on timeout and reset.
REQ-033 Macro undefined: WR_KEY executed for every job; no cache storage.

Verification
REQ-034 Req0 key=0x04030201 word0, pt=0x08070605 word0, handshake cycle T -> writes T+1..T+9, done seen T+15, rsp_valid T+20, rsp_id=0, rsp_ct word0=0x20150C05 (per-byte low-8 products).
REQ-035 req0 and req1 valid same cycle after reset -> req0 served first, req1 second; repeat -> order alternates.
REQ-036 acc_rdata[31] forced 0, TIMEOUT_CYCLES=64 -> rsp_timeout=1, rsp_ct=0 after 65 poll cycles.
REQ-037 rst_n pulsed low during WR_PT -> outputs 0 same cycle, no rsp_valid, next request runs full sequence.
REQ-038 rsp_ready held 0 for 10 cycles -> rsp fields stable, req1_ready stays 0.
REQ-039 KEY_CACHE_EN, two jobs same key -> second job has no writes to 0x28-0x34 and responds 4 cycles earlier.
